serial_frame_tx: RTL and testbench

- Upstream stage of the serial frame receiver FSM; drives that receiver's serial input.
- Captures a parallel payload word on a start request and emits it as one serial frame: idle zeros, the 4-bit preamble 1011, the payload MSB-first, then a guard gap of zeros.
- Advances one bit per clk_en strobe, using the same bit-rate enable the receiver uses.

---
 rtl/serial_frame_tx_pkg.sv | 6 +
 rtl/serial_frame_tx_bit_counter.sv | 18 +
 rtl/serial_frame_tx.sv | 69 ++++++
 tb/tb_serial_frame_tx.sv | 104 ++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: frame states and preamble definition shared by the serial transmitter and receiver.
package serial_frame_tx_pkg;
   typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;
   localparam int PRE_W = 4;
   localparam logic [PRE_W-1:0] PREAMBLE = 4'b1011;
endpackage

// File: rtl/serial_frame_tx_bit_counter.sv
// frame_bit_counter: loadable down-counter gated by the bit strobe, with zero flag.
module frame_bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);
   assign zero = cnt == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends preamble, MSB-first payload and a zero guard gap, one bit per clk_en strobe.
module serial_frame_tx
   import serial_frame_tx_pkg::*;
#(
   parameter int PAYLOAD_W = 10,
   parameter int GAP_BITS  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 start,
   input  logic [PAYLOAD_W-1:0] data_in,
   output logic                 ser_out,
   output logic                 busy,
   output logic                 done
);
   localparam int FW = PRE_W + PAYLOAD_W;
   localparam int MX = PRE_W > PAYLOAD_W ? (PRE_W > GAP_BITS ? PRE_W : GAP_BITS)
                                         : (PAYLOAD_W > GAP_BITS ? PAYLOAD_W : GAP_BITS);
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   state_t state;
   logic [FW-1:0] sr;
   logic [CW-1:0] cnt, ld_val;
   logic zero, load, cnt_en;
   // Preamble and payload share one shift register so the MSB is always the next bit out.
   always_comb begin
      ld_val = state == IDLE ? CW'(PRE_W - 1) : state == PRE ? CW'(PAYLOAD_W - 1) : CW'(GAP_BITS - 1);
      load   = (state == IDLE && start) || (clk_en && zero && (state == PRE || state == PAY));
      cnt_en = clk_en && state != IDLE;
   end
   frame_bit_counter #(.W(CW)) u_cnt (
      .clk(clk), .rst(rst), .en(cnt_en), .load(load),
      .load_val(ld_val), .cnt(cnt), .zero(zero)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         ser_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sr      <= {PREAMBLE, data_in};
               ser_out <= PREAMBLE[PRE_W-1];
               busy    <= 1'b1;
               state   <= PRE;
            end
            PRE, PAY: if (clk_en) begin
               sr <= sr << 1;
               if (state == PAY && zero) begin
                  ser_out <= 1'b0;
                  state   <= GAP;
               end else begin
                  ser_out <= sr[FW-2];
                  if (zero) state <= PAY;
               end
            end
            GAP: if (clk_en && zero) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frames with hand-computed bit sequences, strobe every 4 clks.
module tb_serial_frame_tx;
   logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, start = 1'b0;
   logic [9:0] data_in = '0;
   logic ser_out, busy, done;
   int n_chk = 0, n_fail = 0;

   serial_frame_tx dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
      .data_in(data_in), .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_tick(input bit held);
      @(negedge clk);
      if (held) data_in = 10'($urandom);
   endtask

   // Call at a negedge; returns at the negedge right after the done edge.
   task automatic run_frame(input string tag, input logic [9:0] d, input bit held, input bit acc_en);
      logic [15:0] exp;
      exp = {4'b1011, d, 2'b00};
      data_in = d;
      start = 1'b1;
      clk_en = acc_en;
      @(negedge clk);
      start = held;
      clk_en = 1'b0;
      if (held) data_in = ~d;
      check_eq({tag, " busy@accept"}, busy, 1);
      check_eq({tag, " done@accept"}, done, 0);
      for (int i = 0; i < 16; i++) begin
         repeat (3) idle_tick(held);
         clk_en = 1'b1;
         check_eq($sformatf("%s bit%0d", tag, i), ser_out, exp[15-i]);
         if (i == 15) check_eq({tag, " busy@last"}, busy, 1);
         @(negedge clk);
         clk_en = 1'b0;
      end
      check_eq({tag, " done"}, done, 1);
      check_eq({tag, " busy@done"}, busy, 0);
      check_eq({tag, " ser@done"}, ser_out, 0);
      if (!held) begin
         @(negedge clk);
         check_eq({tag, " done pulse"}, done, 0);
      end
   endtask

   initial begin
      #1;
      check_eq("reset ser_out", ser_out, 0);
      check_eq("reset busy", busy, 0);
      check_eq("reset done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle ignores clk_en", busy, 0);
      clk_en = 1'b0;
      run_frame("basic", 10'b1100110101, 0, 0);
      run_frame("held_a", 10'h2A5, 1, 0);
      run_frame("held_b", 10'h15A, 1, 0);
      run_frame("held_c", 10'h3C3, 0, 0);
      repeat (2) @(negedge clk);
      run_frame("acc_en", 10'h0F1, 0, 1);
      run_frame("zeros", 10'h000, 0, 0);
      run_frame("ones", 10'h3FF, 0, 0);
      // Abort mid-payload: after 5 strobes frame bit 5 (payload MSB-1 = 1) is on the line.
      data_in = 10'b1100110101;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         repeat (3) @(negedge clk);
         clk_en = 1'b1;
         @(negedge clk);
         clk_en = 1'b0;
      end
      check_eq("pre-abort ser_out", ser_out, 1);
      check_eq("pre-abort busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("abort ser_out", ser_out, 0);
      check_eq("abort busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort no done", done, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      run_frame("after_abort", 10'b1010011100, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
